div_radix2: RTL and testbench
=============================

Name: div_radix2

Overview:
- Multi-cycle 32-bit signed/unsigned divider in the EX stage, fed by the ID/EX pipeline register outputs (rd1E, rd2E, alu_controlE).
- Drives stall_div back to the hazard unit, which generates stallE/flushE for the ID/EX register. It is the producing end of the E-stage stall handshake.
- Returns quotient (LO) and remainder (HI) to the EX/MEM path.

Parameters:
- WIDTH, 32, operand/result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high, one clock domain.
- start  in  1  DIV/DIVU is in E and has not completed.
- signed_div  in  1  1 = DIV, 0 = DIVU; sampled with start.
- a  in  WIDTH  dividend (rd1E).
- b  in  WIDTH  divisor (rd2E).
- flush  in  1  E-stage flush (exception/ERET); cancels the operation.
- hold  in  1  E stalled by another source (e.g. memory stall); keeps the result parked.
- stall_div  out  1  request to stall E and earlier stages.
- result_valid  out  1  quotient/remainder valid this cycle.
- lo  out  WIDTH  quotient.
- hi  out  WIDTH  remainder.

Behaviour:
- Reset values: state IDLE, counter 0, stall_div 0, result_valid 0, lo 0, hi 0. Reset mid-operation aborts immediately.
- States: IDLE, BUSY, DONE.
- IDLE, start & ~flush:
  - Latch |a| and |b| (or raw values when unsigned), the quotient sign (a[31]^b[31]) and the remainder sign (a[31]); only when signed.
  - Clear the partial remainder and set counter=0, then go to BUSY.
- BUSY, one restoring iteration per cycle:
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor from the upper WIDTH+1 bits. If non-negative, keep the difference and set quo[0]=1.
  - After WIDTH iterations (counter==WIDTH-1), apply sign correction (two's-complement negate where the sign flag is set), register lo/hi and go to DONE.
- DONE:
  - result_valid=1.
  - If hold, stay in DONE and keep lo/hi stable.
  - Otherwise return to IDLE next cycle.
- stall_div = start & (state != DONE). This is asserted combinationally the same cycle start first rises.
- Latency: start seen at cycle 0, BUSY on cycles 1..32, result_valid and stall_div=0 at cycle 33. E advances on that edge, so the same instruction is never restarted.
- flush in any state: go to IDLE next cycle, result_valid 0, and do not update lo/hi. Flush has priority over start and over completion.
- Divide by zero (b==0, signed or unsigned): lo=0xFFFFFFFF, hi=a. The full 32-cycle latency is still taken, so timing does not depend on the data.
- Signed 0x80000000/0xFFFFFFFF: lo=0x80000000, hi=0. No trap.
- lo/hi hold their last value outside DONE. Only the cycles with result_valid are meaningful.
- start deasserted while in BUSY (not flushed) is illegal. An assertion in the bench must flag it.

Decomposition:
- Shared package (mips_defines): ALU control codes for DIV/DIVU, WIDTH constant, divider state encoding (IDLE/BUSY/DONE as a 2-bit enum).
- Optional sub-module div_abs_neg: combinational conditional two's-complement negate, instantiated for operand magnitude and result correction.
- Everything else lives in div_radix2.

Test Plan:
- Unsigned a=100, b=7, start held: stall_div=1 for cycles 0..32; at cycle 33 result_valid=1, lo=14, hi=2, stall_div=0.
- Signed a=0xFFFFFFF9 (-7), b=2: lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Repeat unsigned with the same operands: lo=0x7FFFFFFC, hi=1.
- Signed 0x80000000/0xFFFFFFFF: lo=0x80000000, hi=0. Divide by zero a=0x12345678, b=0: lo=0xFFFFFFFF, hi=0x12345678, both after 33 cycles.
- flush at cycle 10 of BUSY: state IDLE next cycle and result_valid never asserts. A new start afterwards gives a correct result with full latency.
- hold=1 during DONE for 3 cycles: result_valid stays 1 and lo/hi are stable for 4 cycles total. State returns to IDLE after hold drops.
- rst asserted mid-BUSY: all outputs 0 on the next edge. A back-to-back second division immediately after a completed one has correct results and is not restarted spuriously.

Source files
------------

// File: rtl/div_radix2_pkg.sv
// Shared definitions for the EX-stage radix-2 divider: ALU codes, width and FSM encoding.
package div_radix2_pkg;

  localparam logic [3:0] ALU_DIV   = 4'b1010;
  localparam logic [3:0] ALU_DIVU  = 4'b1011;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_radix2_abs_neg.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fix-up.
module div_radix2_abs_neg #(
  parameter int WIDTH = 32
) (
  input  logic             i_neg,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);

  assign o_dout = i_neg ? (~i_din + WIDTH'(1)) : i_din;

endmodule

// File: rtl/div_radix2.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per cycle, fixed latency,
// stalls E via stall_div until the quotient (lo) and remainder (hi) are ready.
module div_radix2
  import div_radix2_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hold,
  output logic             stall_div,
  output logic             result_valid,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int NEG_A = 0;
  localparam int NEG_B = 1;
  localparam int NEG_Q = 2;
  localparam int NEG_R = 3;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  div_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_valid;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_step;
  logic [WIDTH-1:0] w_quo_step;
  logic             w_unused;

  logic             w_neg_sel [4];
  logic [WIDTH-1:0] w_neg_in  [4];
  logic [WIDTH-1:0] w_neg_out [4];

  // Remainder never exceeds WIDTH bits, so the trial difference's bit WIDTH carries no information.
  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_diff     = {1'b0, w_shift} - {2'b00, r_dvs};
  assign w_ge       = ~w_diff[WIDTH+1];
  assign w_rem_step = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_step = {r_quo[WIDTH-2:0], w_ge};
  assign w_unused   = w_diff[WIDTH];

  assign w_neg_sel[NEG_A] = signed_div & a[WIDTH-1];
  assign w_neg_in[NEG_A]  = a;
  assign w_neg_sel[NEG_B] = signed_div & b[WIDTH-1];
  assign w_neg_in[NEG_B]  = b;
  assign w_neg_sel[NEG_Q] = r_neg_q;
  assign w_neg_in[NEG_Q]  = w_quo_step;
  assign w_neg_sel[NEG_R] = r_neg_r;
  assign w_neg_in[NEG_R]  = w_rem_step;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_neg
      div_radix2_abs_neg #(.WIDTH(WIDTH)) u_neg (
        .i_neg (w_neg_sel[gi]),
        .i_din (w_neg_in[gi]),
        .o_dout(w_neg_out[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_valid <= 1'b0;
      r_lo    <= '0;
      r_hi    <= '0;
    end else if (flush) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_quo   <= w_neg_out[NEG_A];
            r_dvs   <= w_neg_out[NEG_B];
            r_rem   <= '0;
            r_cnt   <= '0;
            // A zero divisor yields an all-ones quotient naturally; leave it un-negated.
            r_neg_q <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]) & (|b);
            r_neg_r <= signed_div & a[WIDTH-1];
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_rem <= w_rem_step;
          r_quo <= w_quo_step;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_ITER) begin
            r_lo    <= w_neg_out[NEG_Q];
            r_hi    <= w_neg_out[NEG_R];
            r_valid <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!hold) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign stall_div    = start & (r_state != ST_DONE);
  assign result_valid = r_valid;
  assign lo           = r_lo;
  assign hi           = r_hi;

endmodule

// File: tb/tb_div_radix2.sv
// Directed bench for div_radix2: arithmetic reference model, per-cycle timing checks,
// flush/hold/reset scenarios and a protocol assertion on start while busy.
module tb_div_radix2;
  import div_radix2_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        hold;
  logic        stall_div;
  logic        result_valid;
  logic [31:0] lo;
  logic [31:0] hi;

  int checks;
  int failures;

  logic [31:0] m_lo;
  logic [31:0] m_hi;
  bit          m_armed;

  div_radix2 #(.WIDTH(32), .CNT_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_div  (signed_div),
    .a           (a),
    .b           (b),
    .flush       (flush),
    .hold        (hold),
    .stall_div   (stall_div),
    .result_valid(result_valid),
    .lo          (lo),
    .hi          (hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic plus the two architectural special cases.
  function automatic void model(input bit sgn, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] q, output logic [31:0] r);
    if (y == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = x;
    end else if (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (sgn) begin
      q = 32'($signed(x) / $signed(y));
      r = 32'($signed(x) % $signed(y));
    end else begin
      q = x / y;
      r = x % y;
    end
  endfunction

  // Whenever the DUT claims a result, it must match the model of the armed transaction.
  always @(negedge clk) begin
    if (result_valid) begin
      chk1("cmp_armed", m_armed, 1'b1);
      chk("cmp_lo", lo, m_lo);
      chk("cmp_hi", hi, m_hi);
    end
  end

  always @(posedge clk) begin
    if (!rst && !flush) begin
      assert (!(dut.r_state == ST_BUSY && !start))
      else begin
        failures++;
        $display("FAIL start_dropped_in_busy actual=start=0 required=start=1");
      end
    end
  end

  // Called between edges; returns between edges on the first cycle after DONE, start low.
  task automatic run_div(input bit sgn, input logic [31:0] da, input logic [31:0] db,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi, input int hold_n);
    model(sgn, da, db, m_lo, m_hi);
    m_armed    = 1'b1;
    start      = 1'b1;
    signed_div = sgn;
    a          = da;
    b          = db;
    hold       = 1'b0;
    #1;
    chk1("stall_c0", stall_div, 1'b1);
    chk1("valid_c0", result_valid, 1'b0);
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      #1;
      chk1("stall_busy", stall_div, 1'b1);
      chk1("valid_busy", result_valid, 1'b0);
    end
    @(negedge clk);
    hold = (hold_n > 0);
    #1;
    chk1("valid_c33", result_valid, 1'b1);
    chk1("stall_c33", stall_div, 1'b0);
    chk("lo_lit", lo, exp_lo);
    chk("hi_lit", hi, exp_hi);
    for (int k = 1; k <= hold_n; k++) begin
      @(negedge clk);
      hold = (k < hold_n);
      #1;
      chk1("valid_hold", result_valid, 1'b1);
      chk("lo_hold", lo, exp_lo);
      chk("hi_hold", hi, exp_hi);
    end
    @(negedge clk);
    m_armed = 1'b0;
    start   = 1'b0;
    hold    = 1'b0;
    #1;
    chk1("valid_end", result_valid, 1'b0);
    $display("div sgn=%0d a=%h b=%h hold=%0d -> lo=%h hi=%h", sgn, da, db, hold_n, exp_lo, exp_hi);
  endtask

  logic [31:0] q_tmp;
  logic [31:0] r_tmp;
  logic [31:0] saved_lo;
  logic [31:0] saved_hi;

  initial begin
    checks     = 0;
    failures   = 0;
    m_armed    = 1'b0;
    m_lo       = '0;
    m_hi       = '0;
    rst        = 1'b1;
    start      = 1'b0;
    signed_div = 1'b0;
    a          = '0;
    b          = '0;
    flush      = 1'b0;
    hold       = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk1("rst_valid", result_valid, 1'b0);
    chk1("rst_stall", stall_div, 1'b0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_hi", hi, 32'd0);
    rst = 1'b0;

    model(1'b0, 32'd100, 32'd7, q_tmp, r_tmp);
    chk("model_u100_7_q", q_tmp, 32'd14);
    chk("model_u100_7_r", r_tmp, 32'd2);
    model(1'b1, 32'hFFFF_FFF9, 32'd2, q_tmp, r_tmp);
    chk("model_sm7_2_q", q_tmp, 32'hFFFF_FFFD);
    chk("model_sm7_2_r", r_tmp, 32'hFFFF_FFFF);
    model(1'b1, 32'h1234_5678, 32'd0, q_tmp, r_tmp);
    chk("model_dz_q", q_tmp, 32'hFFFF_FFFF);
    chk("model_dz_r", r_tmp, 32'h1234_5678);

    @(negedge clk);
    #1;
    run_div(1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         0);
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
    run_div(1'b0, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 32'd1,         0);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         0);
    run_div(1'b1, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 32'h1234_5678, 0);
    run_div(1'b1, 32'h8765_4321, 32'd0,         32'hFFFF_FFFF, 32'h8765_4321, 0);
    run_div(1'b0, 32'h8765_4321, 32'd0,         32'hFFFF_FFFF, 32'h8765_4321, 0);
    run_div(1'b1, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2,         0);
    run_div(1'b0, 32'd1000,      32'd33,        32'd30,        32'd10,        3);

    // Flush in BUSY cycle 10: no result ever, lo/hi keep the previous answer.
    saved_lo   = m_lo;
    saved_hi   = m_hi;
    start      = 1'b1;
    signed_div = 1'b0;
    a          = 32'd500;
    b          = 32'd3;
    for (int c = 1; c <= 10; c++) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    #1;
    chk1("flush_valid", result_valid, 1'b0);
    chk("flush_lo_kept", lo, saved_lo);
    chk("flush_hi_kept", hi, saved_hi);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      chk1("flush_no_valid", result_valid, 1'b0);
    end
    $display("div sgn=0 a=%h b=%h flushed at busy cycle 10", 32'd500, 32'd3);
    run_div(1'b0, 32'd500, 32'd3, 32'd166, 32'd2, 0);

    // Reset in the middle of BUSY clears every output on the next edge.
    start      = 1'b1;
    signed_div = 1'b0;
    a          = 32'h0000_FFFF;
    b          = 32'h0000_0010;
    for (int c = 1; c <= 15; c++) @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    #1;
    chk1("midrst_valid", result_valid, 1'b0);
    chk1("midrst_stall", stall_div, 1'b0);
    chk("midrst_lo", lo, 32'd0);
    chk("midrst_hi", hi, 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk1("postrst_no_valid", result_valid, 1'b0);
    end
    $display("div sgn=0 a=%h b=%h reset at busy cycle 15", 32'h0000_FFFF, 32'h0000_0010);
    run_div(1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 0);
    run_div(1'b0, 32'h0000_FFFF, 32'h0000_0010, 32'h0000_0FFF, 32'h0000_000F, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
